// File: rtl/byte_shift_counter.sv
// Byte-wide shift register plus an independent free-running up counter,
// the front end of the parallel command receiver.
module byte_shift_counter #(
   parameter int DAT_WIDTH = 8,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DAT_WIDTH-1:0]       data_in,
   input  logic                       shift_en,
   input  logic                       shift_clr,
   output logic [DEPTH*DAT_WIDTH-1:0] shifted,
   input  logic                       cnt_en,
   input  logic                       cnt_clr,
   output logic [CNT_WIDTH-1:0]       count,
   output logic                       cnt_max
);

   // Newest word enters at the LSB end; the oldest word falls off the MSB end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shifted <= '0;
      end else if (shift_clr) begin
         shifted <= '0;
      end else if (shift_en) begin
         shifted <= {shifted[(DEPTH-1)*DAT_WIDTH-1:0], data_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (cnt_clr) begin
         count <= '0;
      end else if (cnt_en) begin
         count <= count + 1'b1;
      end
   end

   assign cnt_max = (count == {CNT_WIDTH{1'b1}});

endmodule

// File: tb/tb_byte_shift_counter.sv
// Self-checking bench for byte_shift_counter: directed test-plan steps followed
// by random traffic, compared against a queue/arithmetic reference model.
module tb_byte_shift_counter;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DW-1:0]     dataIn;
   logic              shiftEn;
   logic              shiftClr;
   logic [DEPTH*DW-1:0] shifted;
   logic              cntEn;
   logic              cntClr;
   logic [CW-1:0]     count;
   logic              cntMax;

   logic [DW-1:0]     wordQ[$];
   int                modelCount;
   int                checks = 0;
   int                errors = 0;

   byte_shift_counter #(.DAT_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (dataIn),
      .shift_en  (shiftEn),
      .shift_clr (shiftClr),
      .shifted   (shifted),
      .cnt_en    (cntEn),
      .cnt_clr   (cntClr),
      .count     (count),
      .cnt_max   (cntMax)
   );

   always #5 clk = ~clk;

   // Oldest accepted byte is the most significant digit in base 256.
   function automatic logic [DEPTH*DW-1:0] expectedShifted();
      logic [DEPTH*DW-1:0] v;
      v = '0;
      foreach (wordQ[i]) v = v * 256 + {{(DEPTH*DW-DW){1'b0}}, wordQ[i]};
      return v;
   endfunction

   function automatic void modelReset();
      wordQ.delete();
      modelCount = 0;
   endfunction

   task automatic applyStimulus(input logic se, input logic sc, input logic [DW-1:0] d,
                                input logic ce, input logic cc);
      shiftEn  = se;
      shiftClr = sc;
      dataIn   = d;
      cntEn    = ce;
      cntClr   = cc;
      @(posedge clk);
      if (rst) begin
         if (sc) wordQ.delete();
         else if (se) begin
            wordQ.push_back(d);
            if (wordQ.size() > DEPTH) void'(wordQ.pop_front());
         end
         if (cc) modelCount = 0;
         else if (ce) modelCount = (modelCount + 1) % (1 << CW);
      end
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic [DEPTH*DW-1:0] expShift;
      logic [CW-1:0]       expCount;
      logic                expMax;
      expShift = expectedShifted();
      expCount = CW'(modelCount);
      expMax   = (modelCount == (1 << CW) - 1);
      checks++;
      assert (shifted === expShift) else begin
         errors++;
         $error("FAIL %s shifted observed %h expected %h", tag, shifted, expShift);
      end
      checks++;
      assert (count === expCount) else begin
         errors++;
         $error("FAIL %s count observed %0d expected %0d", tag, count, expCount);
      end
      checks++;
      assert (cntMax === expMax) else begin
         errors++;
         $error("FAIL %s cnt_max observed %b expected %b", tag, cntMax, expMax);
      end
   endtask

   task automatic checkConst(input string tag, input logic [DEPTH*DW-1:0] obsV,
                             input logic [DEPTH*DW-1:0] expV);
      checks++;
      assert (obsV === expV) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obsV, expV);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0;
      shiftEn = 1'b0; shiftClr = 1'b0; dataIn = '0; cntEn = 1'b0; cntClr = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk) rst = 1'b1;

      $display("[TB] byte assembly");
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(8'h11 * (i + 1)), 1'b1, 1'b0);
      checkOutput("assembly");
      checkConst("assembly_word", shifted, 64'h1122334455667788);
      checkConst("assembly_count", 64'(count), 64'd8);

      applyStimulus(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
      checkOutput("overflow");
      checkConst("overflow_word", shifted, 64'h2233445566778899);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
         checkOutput("hold");
      end
      checkConst("hold_word", shifted, 64'h2233445566778899);

      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      checkOutput("shift_clr_priority");
      checkConst("shift_clr_word", shifted, 64'h0);

      $display("[TB] counter wrap");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("cnt_clr");
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("count_15");
      checkConst("count_15_val", 64'({cntMax, count}), 64'h1F);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("count_wrap");
      checkConst("count_wrap_val", 64'({cntMax, count}), 64'h00);

      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkConst("count_7", 64'(count), 64'd7);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("cnt_clr_priority");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("count_hold");
      checkConst("count_hold_val", 64'(count), 64'd3);

      $display("[TB] asynchronous reset");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
      checkOutput("preload");
      #2 rst = 1'b0;
      modelReset();
      #1;
      checkOutput("async_reset_midcycle");
      applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
      checkOutput("reset_held_1");
      applyStimulus(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
      checkOutput("reset_held_2");
      #2 rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
      checkOutput("reset_release");

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom), ($urandom % 10) == 0, 8'($urandom),
                       1'($urandom), ($urandom % 12) == 0);
         checkOutput("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
